// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM states, register map and default address for the I2C grain-sensor target.
package i2c_pkg;
   typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK} state_e;
   localparam logic [1:0] REG_TEMP   = 2'd0;
   localparam logic [1:0] REG_HUMID  = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_THR    = 2'd3;
   localparam logic [6:0] DEFAULT_TGT_ADDR = 7'h48;
endpackage

// File: rtl/i2c_target_if.sv
// i2c_target_if: raw I2C lines plus the open-drain SDA pull-down request.
interface i2c_target_if;
   logic scl_i;
   logic sda_i;
   logic sda_oe;
   modport master (output scl_i, output sda_i, input sda_oe);
   modport slave (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_tgt_sync.sv
// i2c_tgt_sync: 2-flop synchronizers with edge registers; SCL edges and START/STOP detection.
module i2c_tgt_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);
   logic [2:0] scl_q, sda_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         scl_q <= '1;
         sda_q <= '1;
      end else begin
         scl_q <= {scl_q[1:0], scl_i};
         sda_q <= {sda_q[1:0], sda_i};
      end
   assign sda_o      = sda_q[1];
   assign scl_rise_o = scl_q[1] & ~scl_q[2];
   assign scl_fall_o = ~scl_q[1] & scl_q[2];
   assign start_o    = &scl_q[2:1] & sda_q[2] & ~sda_q[1];
   assign stop_o     = &scl_q[2:1] & ~sda_q[2] & sda_q[1];
endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target exposing temp/humid/status/threshold registers and a temp alarm.
// Define I2C_TGT_THR_WR_EN to make the threshold register writable over I2C.
module i2c_target import i2c_pkg::*; #(
   parameter logic [6:0] TGT_ADDR = DEFAULT_TGT_ADDR,
   parameter logic [7:0] THR_RST  = 8'd30
) (
   input  logic         clk,
   input  logic         rst_n,
   i2c_target_if.slave  bus,
   input  logic [7:0]   temp,
   input  logic [7:0]   humid,
   output logic         alarm,
   output logic         start_det,
   output logic         stop_det,
   output logic         busy
);
   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [1:0] ptr_q, ptr_d;
   logic       oe_q, oe_d, first_q, first_d, rw_q, rw_d, busy_q, busy_d, alarm_q;
   logic       sda, scl_rise, scl_fall, start, stop;
   logic [7:0] rx, thr, rd_cur, rd_nxt;

   function automatic logic [7:0] reg_sel(input logic [1:0] p, input logic [7:0] t, h, s, th);
      return p == REG_TEMP ? t : p == REG_HUMID ? h : p == REG_STATUS ? s : th;
   endfunction

   i2c_tgt_sync u_sync (
      .clk(clk), .rst_n(rst_n), .scl_i(bus.scl_i), .sda_i(bus.sda_i), .sda_o(sda),
      .scl_rise_o(scl_rise), .scl_fall_o(scl_fall), .start_o(start), .stop_o(stop)
   );

`ifdef I2C_TGT_THR_WR_EN
   logic [7:0] thr_q, thr_d;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) thr_q <= THR_RST;
      else thr_q <= thr_d;
   assign thr = thr_q;
`else
   assign thr = THR_RST;
`endif

   assign rx     = {shift_q[6:0], sda};
   assign rd_cur = reg_sel(ptr_q, temp, humid, {6'b0, alarm_q, busy_q}, thr);
   assign rd_nxt = reg_sel(ptr_q + 2'd1, temp, humid, {6'b0, alarm_q, busy_q}, thr);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      oe_d    = oe_q;
      ptr_d   = ptr_q;
      first_d = first_q;
      rw_d    = rw_q;
      busy_d  = busy_q;
`ifdef I2C_TGT_THR_WR_EN
      thr_d   = thr_q;
`endif
      if (start) begin
         state_d = ADDR;
         cnt_d   = 3'd0;
         oe_d    = 1'b0;
         first_d = 1'b1;
         busy_d  = 1'b0;
      end else if (stop) begin
         state_d = IDLE;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ADDR: if (scl_rise) begin
               cnt_d   = cnt_q + 3'd1;
               shift_d = rx;
               if (cnt_q == 3'd7) begin
                  state_d = rx[7:1] == TGT_ADDR ? ADDR_ACK : IDLE;
                  rw_d    = rx[0];
               end
            end
            // first fall drives ACK, second fall hands over to the data phase
            ADDR_ACK: if (scl_fall) begin
               if (!oe_q) begin
                  oe_d   = 1'b1;
                  busy_d = 1'b1;
               end else if (rw_q) begin
                  shift_d = rd_cur;
                  oe_d    = ~rd_cur[7];
                  state_d = RD_BYTE;
               end else begin
                  oe_d    = 1'b0;
                  state_d = WR_BYTE;
               end
            end
            WR_BYTE: if (scl_rise) begin
               cnt_d   = cnt_q + 3'd1;
               shift_d = rx;
               if (cnt_q == 3'd7) begin
                  state_d = WR_ACK;
                  first_d = 1'b0;
                  ptr_d   = first_q ? rx[1:0] : ptr_q + 2'd1;
`ifdef I2C_TGT_THR_WR_EN
                  if (!first_q && ptr_q == REG_THR) thr_d = rx;
`endif
               end
            end
            WR_ACK: if (scl_fall) begin
               oe_d = ~oe_q;
               if (oe_q) state_d = WR_BYTE;
            end
            // shift only on falls so SDA never moves while SCL is high
            RD_BYTE: if (scl_rise) begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_d = RD_ACK;
            end else if (scl_fall) begin
               if (cnt_q != 3'd0) begin
                  shift_d = {shift_q[6:0], 1'b0};
                  oe_d    = ~shift_q[6];
               end else oe_d = ~shift_q[7];
            end
            RD_ACK: if (scl_fall) oe_d = 1'b0;
            else if (scl_rise) begin
               if (!sda) begin
                  ptr_d   = ptr_q + 2'd1;
                  shift_d = rd_nxt;
                  state_d = RD_BYTE;
               end else state_d = IDLE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         shift_q <= 8'd0;
         oe_q    <= 1'b0;
         ptr_q   <= 2'd0;
         first_q <= 1'b0;
         rw_q    <= 1'b0;
         busy_q  <= 1'b0;
         alarm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         oe_q    <= oe_d;
         ptr_q   <= ptr_d;
         first_q <= first_d;
         rw_q    <= rw_d;
         busy_q  <= busy_d;
         alarm_q <= temp >= thr;
      end

   assign bus.sda_oe = oe_q;
   assign alarm      = alarm_q;
   assign busy       = busy_q;
   assign start_det  = start;
   assign stop_det   = stop;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed I2C master transactions against i2c_target with hand-computed results.
`timescale 1ns/1ps
module tb_i2c_target;
   import i2c_pkg::*;
`ifdef I2C_TGT_THR_WR_EN
   localparam logic [7:0] THR_EXP  = 8'h20;
   localparam logic       ALARM_1F = 1'b0;
`else
   localparam logic [7:0] THR_EXP  = 8'h1E;
   localparam logic       ALARM_1F = 1'b1;
`endif
   logic clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
   logic [7:0] temp = 8'h00, humid = 8'h55;
   logic alarm, start_det, stop_det, busy;
   int checks = 0, failures = 0, n_start = 0, n_stop = 0, oe_hi = 0;
   int s0, p0, h0, k;
   logic a;
   logic [7:0] d;
   logic [3:0] nib;

   i2c_target_if bus();
   assign bus.scl_i = scl_m;
   assign bus.sda_i = sda_m & ~bus.sda_oe;

   i2c_target dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave), .temp(temp), .humid(humid),
      .alarm(alarm), .start_det(start_det), .stop_det(stop_det), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (start_det) n_start <= n_start + 1;
      if (stop_det) n_stop <= n_stop + 1;
      if (bus.sda_oe) oe_hi <= oe_hi + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic q;
      repeat (5) @(negedge clk);
   endtask

   task automatic bit_slot(input logic b, output logic s);
      sda_m = b;
      q;
      scl_m = 1'b1;
      q;
      s = bus.sda_i;
      q;
      scl_m = 1'b0;
      q;
   endtask

   task automatic i2c_start;
      sda_m = 1'b1;
      q;
      scl_m = 1'b1;
      q;
      sda_m = 1'b0;
      q;
      scl_m = 1'b0;
      q;
   endtask

   task automatic i2c_stop;
      sda_m = 1'b0;
      q;
      scl_m = 1'b1;
      q;
      sda_m = 1'b1;
      q;
   endtask

   task automatic wr(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_slot(b[i], s);
      bit_slot(1'b1, ack);
   endtask

   task automatic rd(input logic ack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) bit_slot(1'b1, b[i]);
      bit_slot(ack, s);
   endtask

   task automatic wr_ack(input string tag, input logic [7:0] b);
      logic ack;
      wr(b, ack);
      check(tag, 32'(ack), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
      check("rst_alarm", 32'(alarm), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_start_det", 32'(start_det), 32'd0);
      check("rst_stop_det", 32'(stop_det), 32'd0);
      check("rst_state", 32'(dut.state_q), 32'(IDLE));
      rst_n = 1'b1;
      q;
      check("alarm_idle", 32'(alarm), 32'd0);

      // write pointer 0, repeated START, read temp with NACK
      temp = 8'h1A;
      s0 = n_start;
      p0 = n_stop;
      i2c_start;
      wr_ack("w_addr_ack", 8'h90);
      check("busy_after_ack", 32'(busy), 32'd1);
      wr_ack("w_ptr_ack", 8'h00);
      i2c_start;
      wr_ack("r_addr_ack", 8'h91);
      rd(1'b1, d);
      check("rd_temp", 32'(d), 32'h1A);
      check("sda_released", 32'(bus.sda_oe), 32'd0);
      i2c_stop;
      q;
      check("busy_after_stop", 32'(busy), 32'd0);
      check("start_count", 32'(n_start - s0), 32'd2);
      check("stop_count", 32'(n_stop - p0), 32'd1);

      // five-byte read from pointer 2 wraps through the map
      i2c_start;
      wr_ack("w2_addr", 8'h90);
      wr_ack("w2_ptr", 8'h02);
      i2c_start;
      wr_ack("r2_addr", 8'h91);
      rd(1'b0, d); check("rd5_status", 32'(d), 32'h01);
      rd(1'b0, d); check("rd5_thr", 32'(d), 32'h1E);
      rd(1'b0, d); check("rd5_temp", 32'(d), 32'h1A);
      rd(1'b0, d); check("rd5_humid", 32'(d), 32'h55);
      rd(1'b1, d); check("rd5_status_wrap", 32'(d), 32'h01);
      i2c_stop;
      q;

      // threshold write
      temp = 8'h25;
      i2c_start;
      wr_ack("thr_addr", 8'h90);
      wr_ack("thr_ptr", 8'h03);
      wr_ack("thr_data", 8'h20);
      repeat (2) @(negedge clk);
      check("alarm_25", 32'(alarm), 32'd1);
      i2c_stop;
      i2c_start;
      wr_ack("thr_rd_addr", 8'h90);
      wr_ack("thr_rd_ptr", 8'h03);
      i2c_start;
      wr_ack("thr_rd_addr2", 8'h91);
      rd(1'b1, d);
      check("thr_value", 32'(d), 32'(THR_EXP));
      i2c_stop;
      temp = 8'h1F;
      repeat (3) @(negedge clk);
      check("alarm_1f", 32'(alarm), 32'(ALARM_1F));

      // write at pointer 3 wraps pointer to 0
      i2c_start;
      wr_ack("wrap_addr", 8'h90);
      wr_ack("wrap_ptr", 8'h03);
      wr_ack("wrap_data", 8'h1E);
      i2c_stop;
      i2c_start;
      wr_ack("wrap_rd_addr", 8'h91);
      rd(1'b1, d);
      check("wrap_rd_temp", 32'(d), 32'h1F);
      i2c_stop;

      // write to read-only temp is ACKed, discarded, pointer moves on
      i2c_start;
      wr_ack("ro_addr", 8'h90);
      wr_ack("ro_ptr", 8'h00);
      wr_ack("ro_data", 8'h77);
      i2c_stop;
      i2c_start;
      wr_ack("ro_rd_addr", 8'h91);
      rd(1'b1, d);
      check("ro_rd_humid", 32'(d), 32'h55);
      i2c_stop;

      // foreign address is ignored
      h0 = oe_hi;
      i2c_start;
      wr(8'h92, a);
      check("foreign_nack", 32'(a), 32'd1);
      check("foreign_busy", 32'(busy), 32'd0);
      i2c_stop;
      check("foreign_no_oe", 32'(oe_hi - h0), 32'd0);

      // STOP injected after four read bits of 0x1F
      i2c_start;
      wr_ack("abort_addr", 8'h90);
      wr_ack("abort_ptr", 8'h00);
      i2c_start;
      wr_ack("abort_raddr", 8'h91);
      for (int i = 3; i >= 0; i--) bit_slot(1'b1, nib[i]);
      check("abort_bits", 32'(nib), 32'h1);
      p0 = n_stop;
      k = 0;
      sda_m = 1'b0;
      q;
      scl_m = 1'b1;
      q;
      sda_m = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (stop_det) k++;
      end
      check("abort_stop_pulse", 32'(k), 32'd1);
      check("abort_state", 32'(dut.state_q), 32'(IDLE));
      check("abort_sda_oe", 32'(bus.sda_oe), 32'd0);
      q;

      // async reset while driving a 0 in RD_BYTE
      temp = 8'h1A;
      i2c_start;
      wr_ack("rst_addr", 8'h90);
      wr_ack("rst_ptr", 8'h00);
      i2c_start;
      wr_ack("rst_raddr", 8'h91);
      check("rst_driving", 32'(bus.sda_oe), 32'd1);
      #3 rst_n = 1'b0;
      #1 check("rst_async_release", 32'(bus.sda_oe), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      h0 = oe_hi;
      rd(1'b1, d);
      i2c_stop;
      check("rst_frame_ignored", 32'(oe_hi - h0), 32'd0);
      i2c_start;
      wr_ack("post_addr", 8'h90);
      wr_ack("post_ptr", 8'h00);
      i2c_start;
      wr_ack("post_raddr", 8'h91);
      rd(1'b1, d);
      check("post_rd_temp", 32'(d), 32'h1A);
      i2c_stop;
      q;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
